// File: rtl/bank_isu_credit_return.sv
// ============================================================================
// Module   : bank_isu_credit_return
// Purpose  : Per-channel read-response FIFOs with round-robin arbitration onto
//            one valid/ready port and a registered credit-release pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bank_isu_credit_return #(
    parameter int CHANNEL_NUM = 3,
    parameter int PTR_WIDTH   = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int BUF_DEPTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHANNEL_NUM-1:0]            ch_rsp_valid,
    input  logic [CHANNEL_NUM*PTR_WIDTH-1:0]  ch_rsp_id,
    input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] ch_rsp_data,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [PTR_WIDTH-1:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic [1:0]                        rsp_ch_id,
    output logic [CHANNEL_NUM-1:0]            channels_credit_release,
    output logic                              overflow_err
);

    localparam int              c_AW      = $clog2(BUF_DEPTH);
    localparam int              c_CW      = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(BUF_DEPTH);
    localparam logic [1:0]      c_LAST_CH = 2'(CHANNEL_NUM - 1);

    logic [PTR_WIDTH-1:0]   r_mem_id   [CHANNEL_NUM][BUF_DEPTH];
    logic [DATA_WIDTH-1:0]  r_mem_data [CHANNEL_NUM][BUF_DEPTH];
    logic [c_AW-1:0]        r_wr_ptr   [CHANNEL_NUM];
    logic [c_AW-1:0]        r_rd_ptr   [CHANNEL_NUM];
    logic [c_CW-1:0]        r_count    [CHANNEL_NUM];
    logic [1:0]             r_rr_ptr;
    logic                   r_lock;
    logic [1:0]             r_lock_ch;
    logic [CHANNEL_NUM-1:0] r_credit;
    logic                   r_ovf;

    logic [1:0]             w_scan_ch;
    logic                   w_found;
    logic [1:0]             w_gnt;
    logic                   w_valid;
    logic                   w_hs;
    logic [CHANNEL_NUM-1:0] w_pop;
    logic [CHANNEL_NUM-1:0] w_push;
    logic [CHANNEL_NUM-1:0] w_drop;

    // First non-empty channel starting at the round-robin pointer.
    always_comb begin
        logic [2:0] idx;
        w_found   = 1'b0;
        w_scan_ch = r_rr_ptr;
        idx       = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            idx = {1'b0, r_rr_ptr} + 3'(k);
            if (idx >= 3'(CHANNEL_NUM)) idx = idx - 3'(CHANNEL_NUM);
            if (!w_found && (r_count[idx[1:0]] != '0)) begin
                w_found   = 1'b1;
                w_scan_ch = idx[1:0];
            end
        end
    end

    // A stalled grant keeps its channel so the presented beat stays stable.
    assign w_gnt   = r_lock ? r_lock_ch : w_scan_ch;
    assign w_valid = (r_count[w_gnt] != '0);
    assign w_hs    = w_valid & rsp_ready;

    always_comb begin
        w_pop  = '0;
        w_push = '0;
        w_drop = '0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            w_pop[c]  = w_hs && (w_gnt == 2'(c));
            w_push[c] = ch_rsp_valid[c] && ((r_count[c] != c_FULL) || w_pop[c]);
            w_drop[c] = ch_rsp_valid[c] && (r_count[c] == c_FULL) && !w_pop[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
            r_credit  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_count[c] <= r_count[c] + 1'b1;
                    2'b01:   r_count[c] <= r_count[c] - 1'b1;
                    default: r_count[c] <= r_count[c];
                endcase
            end
            if (w_hs) r_rr_ptr <= (w_gnt == c_LAST_CH) ? 2'd0 : w_gnt + 2'd1;
            r_lock    <= w_valid & ~rsp_ready;
            r_lock_ch <= w_gnt;
            r_credit  <= w_pop;
            r_ovf     <= r_ovf | (|w_drop);
        end
    end

    // Storage needs no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            if (w_push[c]) begin
                r_mem_id[c][r_wr_ptr[c]]   <= ch_rsp_id[c*PTR_WIDTH +: PTR_WIDTH];
                r_mem_data[c][r_wr_ptr[c]] <= ch_rsp_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rsp_valid               = w_valid;
    assign rsp_id                  = w_valid ? r_mem_id[w_gnt][r_rd_ptr[w_gnt]]   : '0;
    assign rsp_data                = w_valid ? r_mem_data[w_gnt][r_rd_ptr[w_gnt]] : '0;
    assign rsp_ch_id               = w_valid ? w_gnt : 2'd0;
    assign channels_credit_release = r_credit;
    assign overflow_err            = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bank_isu_credit_return.sv
// ============================================================================
// Module   : tb_bank_isu_credit_return
// Purpose  : Directed self-checking bench for bank_isu_credit_return.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bank_isu_credit_return;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   ch_rsp_valid;
    logic [23:0]  ch_rsp_id;
    logic [191:0] ch_rsp_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [7:0]   rsp_id;
    logic [63:0]  rsp_data;
    logic [1:0]   rsp_ch_id;
    logic [2:0]   channels_credit_release;
    logic         overflow_err;

    int n_pass = 0;
    int n_chk  = 0;

    bank_isu_credit_return #(
        .CHANNEL_NUM(3), .PTR_WIDTH(8), .DATA_WIDTH(64), .BUF_DEPTH(8)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ch_rsp_valid            (ch_rsp_valid),
        .ch_rsp_id               (ch_rsp_id),
        .ch_rsp_data             (ch_rsp_data),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_id                  (rsp_id),
        .rsp_data                (rsp_data),
        .rsp_ch_id               (rsp_ch_id),
        .channels_credit_release (channels_credit_release),
        .overflow_err            (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; pushes are single-cycle so they clear by default.
    task automatic cyc();
        @(posedge clk);
        #1;
        ch_rsp_valid = '0;
    endtask

    task automatic push(input int c, input logic [7:0] id, input logic [63:0] d);
        ch_rsp_valid[c]       = 1'b1;
        ch_rsp_id[c*8 +: 8]   = id;
        ch_rsp_data[c*64 +: 64] = d;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        ch_rsp_valid = '0; ch_rsp_id = '0; ch_rsp_data = '0;
        cyc(); cyc();
        rst = 1'b0; #1;
        chk("reset_valid",   64'(rsp_valid), 64'd0);
        chk("reset_credit",  64'(channels_credit_release), 64'd0);
        chk("reset_ovf",     64'(overflow_err), 64'd0);
        chk("reset_id",      64'(rsp_id), 64'd0);
        chk("reset_chid",    64'(rsp_ch_id), 64'd0);

        // Single push on ch1: no bypass, visible next cycle, pulse after pop.
        cyc(); rsp_ready = 1'b1; push(1, 8'h05, 64'hA5); #1;
        chk("single_nobypass", 64'(rsp_valid), 64'd0);
        cyc(); #1;
        chk("single_valid",  64'(rsp_valid), 64'd1);
        chk("single_chid",   64'(rsp_ch_id), 64'd1);
        chk("single_id",     64'(rsp_id), 64'h05);
        chk("single_data",   rsp_data, 64'hA5);
        chk("single_nocred", 64'(channels_credit_release), 64'd0);
        cyc(); #1;
        chk("single_cred",   64'(channels_credit_release), 64'b010);
        chk("single_empty",  64'(rsp_valid), 64'd0);
        cyc(); #1;
        chk("single_cred_off", 64'(channels_credit_release), 64'd0);

        // Reset so the round-robin pointer starts at 0.
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;

        // Three simultaneous pushes drain in order 0,1,2.
        cyc(); push(0, 8'h10, 64'h100); push(1, 8'h11, 64'h101); push(2, 8'h12, 64'h102); #1;
        cyc(); #1;
        chk("rr0_chid", 64'(rsp_ch_id), 64'd0);
        chk("rr0_id",   64'(rsp_id), 64'h10);
        chk("rr0_cred", 64'(channels_credit_release), 64'd0);
        cyc(); #1;
        chk("rr1_chid", 64'(rsp_ch_id), 64'd1);
        chk("rr1_id",   64'(rsp_id), 64'h11);
        chk("rr1_cred", 64'(channels_credit_release), 64'b001);
        cyc(); #1;
        chk("rr2_chid", 64'(rsp_ch_id), 64'd2);
        chk("rr2_data", rsp_data, 64'h102);
        chk("rr2_cred", 64'(channels_credit_release), 64'b010);
        cyc(); #1;
        chk("rr_done_valid", 64'(rsp_valid), 64'd0);
        chk("rr_done_cred",  64'(channels_credit_release), 64'b100);

        // Grant lock: rr_ptr is 0, ch2 stalls, ch0 arriving must not steal.
        cyc(); rsp_ready = 1'b0; push(2, 8'h22, 64'h2222); #1;
        cyc(); push(0, 8'h30, 64'h3030); #1;
        chk("lock_first_chid", 64'(rsp_ch_id), 64'd2);
        cyc(); #1;
        chk("lock_hold_chid", 64'(rsp_ch_id), 64'd2);
        chk("lock_hold_id",   64'(rsp_id), 64'h22);
        chk("lock_hold_data", rsp_data, 64'h2222);
        cyc(); rsp_ready = 1'b1; #1;
        chk("lock_release_chid", 64'(rsp_ch_id), 64'd2);
        cyc(); #1;
        chk("lock_next_chid", 64'(rsp_ch_id), 64'd0);
        chk("lock_next_id",   64'(rsp_id), 64'h30);
        chk("lock_next_cred", 64'(channels_credit_release), 64'b100);
        cyc(); #1;
        chk("lock_end_valid", 64'(rsp_valid), 64'd0);
        chk("lock_end_cred",  64'(channels_credit_release), 64'b001);

        // Fill ch0, then push+pop at full, then drain in order.
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(); push(0, 8'(i), 64'(i) + 64'h5000);
        end
        cyc(); #1;
        chk("full_head_id", 64'(rsp_id), 64'h00);
        rsp_ready = 1'b1; push(0, 8'h08, 64'h5008); #1;
        for (int k = 1; k <= 8; k++) begin
            cyc(); #1;
            chk($sformatf("drain_id%0d", k),   64'(rsp_id), 64'(k));
            chk($sformatf("drain_cred%0d", k), 64'(channels_credit_release), 64'b001);
        end
        chk("drain_last_data", rsp_data, 64'h5008);
        chk("pushpop_full_ovf", 64'(overflow_err), 64'd0);
        cyc(); #1;
        chk("drain_empty", 64'(rsp_valid), 64'd0);
        chk("drain_cred9", 64'(channels_credit_release), 64'b001);
        cyc(); #1;
        chk("drain_cred_off", 64'(channels_credit_release), 64'd0);

        // Overflow: push into full ch0 with no pop is dropped and sticky.
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(); push(0, 8'h40 + 8'(i), 64'h40 + 64'(i));
        end
        cyc(); #1;
        chk("ovf_pre", 64'(overflow_err), 64'd0);
        push(0, 8'h48, 64'h48); #1;
        cyc(); #1;
        chk("ovf_set", 64'(overflow_err), 64'd1);
        chk("ovf_head", 64'(rsp_id), 64'h40);
        rsp_ready = 1'b1; #1;
        for (int k = 1; k < 8; k++) begin
            cyc(); #1;
            chk($sformatf("ovf_drain_id%0d", k), 64'(rsp_id), 64'h40 + 64'(k));
        end
        cyc(); #1;
        chk("ovf_no_dropped", 64'(rsp_valid), 64'd0);
        chk("ovf_sticky", 64'(overflow_err), 64'd1);

        // Reset with 5 buffered entries and a push in the reset cycle.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); push(1, 8'h50 + 8'(i), 64'h50);
            if (i < 2) push(2, 8'h60 + 8'(i), 64'h60);
        end
        cyc(); #1;
        chk("prerst_valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1; rsp_ready = 1'b1; push(0, 8'h70, 64'h70); #1;
        cyc(); rst = 1'b0; #1;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_cred",  64'(channels_credit_release), 64'd0);
        chk("rst_ovf",   64'(overflow_err), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk($sformatf("rst_quiet_valid%0d", k), 64'(rsp_valid), 64'd0);
            chk($sformatf("rst_quiet_cred%0d", k),  64'(channels_credit_release), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
